// File: rtl/FP_special_values.sv
// Shared IEEE-754 single-precision constants and the divider state type.
package FP_special_values;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_NEG_INF  = 32'hFF80_0000;
  localparam logic [31:0] FP_NAN      = 32'h7FC0_0000;

  // One quotient bit per CALC cycle; 25 bits cover the [0.5, 2) quotient range.
  localparam int unsigned CALC_CYCLES = 25;
  localparam logic [4:0]  CALC_LAST   = 5'(CALC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    NORM,
    DONE
  } state_t;

  // Signed zero or signed infinity selected by the result sign.
  function automatic logic [31:0] signed_zero(input logic sign);
    return sign ? FP_NEG_ZERO : FP_POS_ZERO;
  endfunction

  function automatic logic [31:0] signed_inf(input logic sign);
    return sign ? FP_NEG_INF : FP_POS_INF;
  endfunction

endpackage

// File: rtl/FP_classify.sv
// Operand class decode: exponent-0 values (zero and denormals) count as zero.
module FP_classify (
  input  logic [30:0] val,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);

  logic exp_zero;
  logic exp_ones;
  logic man_zero;

  assign exp_zero = (val[30:23] == 8'h00);
  assign exp_ones = (val[30:23] == 8'hFF);
  assign man_zero = (val[22:0] == 23'h0);

  assign is_zero = exp_zero;
  assign is_inf  = exp_ones & man_zero;
  assign is_nan  = exp_ones & ~man_zero;

endmodule

// File: rtl/fp_div.sv
// Single-precision divider: restoring mantissa division, truncating rounding,
// fixed latency regardless of operand class.
module fp_div
  import FP_special_values::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] OUT,
  output logic        div_by_zero
);

  state_t state_q, state_d;

  logic [30:0]       a_q, b_q;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [23:0]       divisor_q;
  logic [25:0]       rem_q;
  logic [24:0]       quot_q;
  logic [4:0]        cnt_q;
  logic [31:0]       out_q;
  logic              dbz_q;

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;

  logic [25:0]       diff;
  logic              q_bit;
  logic [25:0]       rem_nxt;
  logic signed [9:0] norm_exp;
  logic [22:0]       frac;
  logic              spec_hit;
  logic              spec_dbz;
  logic [31:0]       spec_val;
  logic [31:0]       result;

  FP_classify u_class_a (
    .val     (a_q),
    .is_zero (a_zero),
    .is_inf  (a_inf),
    .is_nan  (a_nan)
  );

  FP_classify u_class_b (
    .val     (b_q),
    .is_zero (b_zero),
    .is_inf  (b_inf),
    .is_nan  (b_nan)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start is only looked at in IDLE, so it is ignored while busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CALC_LAST) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One restoring-division step; remainder stays below 2*divisor so 26 bits suffice.
  always_comb begin
    diff    = rem_q - {2'b00, divisor_q};
    q_bit   = ~diff[25];
    rem_nxt = q_bit ? {diff[24:0], 1'b0} : {rem_q[24:0], 1'b0};
  end

  // Normalise, truncate, and pick the special-case result by operand class.
  always_comb begin
    norm_exp = quot_q[24] ? exp_q : exp_q - 10'sd1;
    frac     = quot_q[24] ? quot_q[23:1] : quot_q[22:0];

    spec_hit = 1'b1;
    spec_dbz = 1'b0;
    spec_val = FP_NAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_val = FP_NAN;
    end else if (a_inf) begin
      spec_val = signed_inf(sign_q);
    end else if (b_inf) begin
      spec_val = signed_zero(sign_q);
    end else if (b_zero) begin
      spec_val = signed_inf(sign_q);
      spec_dbz = 1'b1;
    end else if (a_zero) begin
      spec_val = signed_zero(sign_q);
    end else begin
      spec_hit = 1'b0;
    end

    if (spec_hit) begin
      result = spec_val;
    end else if (norm_exp <= 10'sd0) begin
      result = signed_zero(sign_q);
    end else if (norm_exp >= 10'sd255) begin
      result = signed_inf(sign_q);
    end else begin
      result = {sign_q, norm_exp[7:0], frac};
    end
  end

  // Datapath: latch on accept, iterate in CALC, publish the result entering DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      out_q     <= FP_POS_ZERO;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q       <= A[30:0];
            b_q       <= B[30:0];
            sign_q    <= A[31] ^ B[31];
            exp_q     <= $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + 10'sd127;
            rem_q     <= {2'b01, A[22:0]};
            divisor_q <= {1'b1, B[22:0]};
            quot_q    <= '0;
            cnt_q     <= '0;
          end
        end
        CALC: begin
          rem_q  <= rem_nxt;
          quot_q <= {quot_q[23:0], q_bit};
          cnt_q  <= cnt_q + 5'd1;
        end
        NORM: begin
          exp_q <= norm_exp;
          out_q <= result;
          dbz_q <= spec_hit & spec_dbz;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign OUT         = out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/fp_div.md
FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have port start, input, 1, request to begin a divide; accepted only when busy=0.
REQ-004 SHALL have port A, input, 32, IEEE-754 single-precision dividend, sampled on the accepting edge.
REQ-005 SHALL have port B, input, 32, IEEE-754 single-precision divisor, sampled on the accepting edge.
REQ-006 SHALL have port busy, output, 1, high from the accepting edge until done deasserts.
REQ-007 SHALL have port done, output, 1, one-cycle pulse; OUT valid when high.
REQ-008 SHALL have port OUT, output, 32, quotient A/B; held stable until the next accepted start.
REQ-009 SHALL have port div_by_zero, output, 1, set with done when B is zero and A is finite nonzero; held with OUT.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, NORM, DONE.
REQ-011 SHALL, in IDLE with start=1, latch A/B, compute sign = A[31]^B[31], compute biased exponent ExpA-ExpB+127 in 10-bit signed form, and enter CALC.
REQ-012 SHALL, in CALC, run restoring division of 24-bit mantissas (hidden 1 restored), one quotient bit per cycle, for exactly 25 cycles, then enter NORM.
REQ-013 SHALL, in NORM, left-shift the quotient by one and decrement the exponent when quotient MSB=0, then enter DONE.
REQ-014 SHALL round toward zero (truncate); the remainder is discarded.
REQ-015 SHALL, in DONE, assert done for one cycle, update OUT/div_by_zero, and return to IDLE.
REQ-016 SHALL have a fixed latency: done high exactly 27 cycles after the accepting edge, for all operand classes.
REQ-017 SHALL ignore start while busy=1; operands presented then are not sampled.
REQ-018 SHALL treat exponent-0 inputs (zero/denormal) as signed zero.
REQ-019 SHALL return signed zero when the result exponent is <=0 (flush underflow).
REQ-020 SHALL return signed infinity when the result exponent is >=255 (overflow).
REQ-021 SHALL produce these special results: NaN operand, 0/0 or inf/inf -> 0x7FC00000; x/0 (finite nonzero x) -> signed inf with div_by_zero=1; inf/finite -> signed inf; finite/inf -> signed zero; 0/finite nonzero -> signed zero.
REQ-022 SHALL allow start in the same cycle done is high to be ignored, because the FSM is still in DONE; it is accepted from the following IDLE cycle.

Reset
REQ-023 SHALL, on rst_n=0 at a clock edge, enter IDLE and clear busy=0, done=0, OUT=0x00000000, div_by_zero=0, and all datapath registers.
REQ-024 SHALL abort an in-flight divide on reset with no done pulse; the next start after rst_n=1 begins a full 27-cycle operation.

Structure
REQ-025 SHALL take FP_POS_ZERO, FP_NEG_ZERO, FP_POS_INF, FP_NEG_INF, FP_NAN (0x7FC00000) from shared package FP_special_values; the state enum typedef also lives there.
REQ-026 SHALL keep the operand classifier (zero/inf/NaN decode per operand) as sub-module FP_classify, reusable by FP_mul and FP_div.
REQ-027 SHALL be 120-400 lines of RTL excluding the package.

Verification
REQ-028 SHALL check A=0x40C00000 (6.0), B=0x40000000 (2.0), start pulse -> done exactly 27 cycles later, OUT=0x40400000 (3.0), div_by_zero=0.
REQ-029 SHALL check A=0x3F800000, B=0x00000000 -> OUT=0x7F800000, div_by_zero=1; A=0x00000000, B=0x00000000 -> OUT=0x7FC00000, div_by_zero=0.
REQ-030 SHALL check A=0x7F000000, B=0x00800000 -> OUT=0x7F800000 (overflow); A=0x00800000, B=0x7F000000 -> OUT=0x00000000 (underflow).
REQ-031 SHALL check a second start asserted 5 cycles into an operation -> ignored; OUT equals the first quotient; no extra done pulse.
REQ-032 SHALL check rst_n=0 asserted at cycle 10 of a divide -> busy=0, OUT=0 on the next edge, and no done pulse.
REQ-033 SHALL run 100 random $random operand pairs against shortreal a/b -> |OUT - $shortrealtobits(a/b)| <= 1 ulp, with sign matching.
